// File: rtl/tinymips_controller.sv
// Multicycle Moore control unit for the TinyMIPS 8-bit core.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky HALT state.
module tinymips_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       iord,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [3:0] irwrite,
    output logic [2:0] alucont,
    output logic       halted
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
        MEMADR, LBRD, LBWR, SBWR,
        RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
`ifdef CTRL_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    // pcwrite/branch are kept separately so pcen can follow zero combinationally.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic [2:0] alucont;
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic       halted;
`endif
    } ctrl_t;

    state_t state;
    state_t state_nx;
    ctrl_t  ctrl;
    logic   live;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] o);
        case (s)
            FETCH1:  next_of = FETCH2;
            FETCH2:  next_of = FETCH3;
            FETCH3:  next_of = FETCH4;
            FETCH4:  next_of = DECODE;
            DECODE: begin
                case (o)
                    OP_LB, OP_SB: next_of = MEMADR;
                    OP_RTYPE:     next_of = RTYPEEX;
                    OP_BEQ:       next_of = BEQEX;
                    OP_J:         next_of = JEX;
                    OP_ADDI:      next_of = ADDIEX;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      next_of = HALT;
`else
                    default:      next_of = FETCH1;
`endif
                endcase
            end
            MEMADR:  next_of = (o == OP_LB) ? LBRD : SBWR;
            LBRD:    next_of = LBWR;
            RTYPEEX: next_of = RTYPEWR;
            ADDIEX:  next_of = ADDIWR;
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT:    next_of = HALT;
`endif
            default: next_of = FETCH1;
        endcase
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.alucont = ALU_ADD;
                c.pcwrite = 1'b1;
                case (s)
                    FETCH1:  c.irwrite = 4'b1000;
                    FETCH2:  c.irwrite = 4'b0100;
                    FETCH3:  c.irwrite = 4'b0010;
                    default: c.irwrite = 4'b0001;
                endcase
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                c.alucont = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.alucont = ALU_ADD;
            end
            LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alucont = funct_alu(f);
            end
            RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BEQEX: begin
                c.alusrca  = 1'b1;
                c.alucont  = ALU_SUB;
                c.pcsource = 2'b01;
                c.branch   = 1'b1;
            end
            JEX: begin
                c.pcsource = 2'b10;
                c.pcwrite  = 1'b1;
            end
            ADDIWR:  c.regwrite = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT:    c.halted = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_nx = next_of(state, op);

    // Outputs are registered from the next state so they line up with the
    // state they belong to. After reset release one edge is spent loading
    // FETCH1's outputs while the state stays at FETCH1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH1;
            ctrl  <= '0;
            live  <= 1'b0;
        end else if (!live) begin
            live  <= 1'b1;
            ctrl  <= ctrl_of(FETCH1, funct);
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_of(state_nx, funct);
        end
    end

    assign memread  = ctrl.memread;
    assign memwrite = ctrl.memwrite;
    assign alusrca  = ctrl.alusrca;
    assign memtoreg = ctrl.memtoreg;
    assign iord     = ctrl.iord;
    assign regwrite = ctrl.regwrite;
    assign regdst   = ctrl.regdst;
    assign pcsource = ctrl.pcsource;
    assign alusrcb  = ctrl.alusrcb;
    assign irwrite  = ctrl.irwrite;
    assign alucont  = ctrl.alucont;
    assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = ctrl.halted;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_tinymips_controller.sv
// Directed, table-driven bench for tinymips_controller: per-instruction state
// sequences plus reset-abort and illegal-opcode sequences.
module tb_tinymips_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
    logic [1:0] pcsource, alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucont;
    logic       halted;

    tinymips_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca),
        .memtoreg(memtoreg), .iord(iord), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
        .irwrite(irwrite), .alucont(alucont), .halted(halted)
    );

    always #5 clk = ~clk;

    // {memread,memwrite,alusrca,memtoreg,iord,pcen,regwrite,regdst,pcsource,alusrcb,irwrite,alucont,halted}
    logic [19:0] outs;
    assign outs = {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
                   pcsource, alusrcb, irwrite, alucont, halted};

    localparam logic [19:0] ZERO   = 20'b0;
    localparam logic [19:0] F1     = 20'b1_0_0_0_0_1_0_0_00_01_1000_010_0;
    localparam logic [19:0] F2     = 20'b1_0_0_0_0_1_0_0_00_01_0100_010_0;
    localparam logic [19:0] F3     = 20'b1_0_0_0_0_1_0_0_00_01_0010_010_0;
    localparam logic [19:0] F4     = 20'b1_0_0_0_0_1_0_0_00_01_0001_010_0;
    localparam logic [19:0] DEC    = 20'b0_0_0_0_0_0_0_0_00_11_0000_010_0;
    localparam logic [19:0] MEMADR = 20'b0_0_1_0_0_0_0_0_00_10_0000_010_0;
    localparam logic [19:0] LBRD   = 20'b1_0_0_0_1_0_0_0_00_00_0000_000_0;
    localparam logic [19:0] LBWR   = 20'b0_0_0_1_0_0_1_0_00_00_0000_000_0;
    localparam logic [19:0] SBWR   = 20'b0_1_0_0_1_0_0_0_00_00_0000_000_0;
    localparam logic [19:0] RT_SUB = 20'b0_0_1_0_0_0_0_0_00_00_0000_110_0;
    localparam logic [19:0] RT_SLT = 20'b0_0_1_0_0_0_0_0_00_00_0000_111_0;
    localparam logic [19:0] RT_ADD = 20'b0_0_1_0_0_0_0_0_00_00_0000_010_0;
    localparam logic [19:0] RT_AND = 20'b0_0_1_0_0_0_0_0_00_00_0000_000_0;
    localparam logic [19:0] RT_OR  = 20'b0_0_1_0_0_0_0_0_00_00_0000_001_0;
    localparam logic [19:0] RTWR   = 20'b0_0_0_0_0_0_1_1_00_00_0000_000_0;
    localparam logic [19:0] BEQ_T  = 20'b0_0_1_0_0_1_0_0_01_00_0000_110_0;
    localparam logic [19:0] BEQ_N  = 20'b0_0_1_0_0_0_0_0_01_00_0000_110_0;
    localparam logic [19:0] JEX    = 20'b0_0_0_0_0_1_0_0_10_00_0000_000_0;
    localparam logic [19:0] ADDIEX = 20'b0_0_1_0_0_0_0_0_00_10_0000_010_0;
    localparam logic [19:0] ADDIWR = 20'b0_0_0_0_0_0_1_0_00_00_0000_000_0;
    localparam logic [19:0] HALTV  = 20'b0_0_0_0_0_0_0_0_00_00_0000_000_1;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          ncyc;
        logic [19:0] e0, e1, e2;
    } rec_t;

    rec_t recs[12];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] front(input int c);
        case (c)
            1:       front = F1;
            2:       front = F2;
            3:       front = F3;
            4:       front = F4;
            default: front = DEC;
        endcase
    endfunction

    initial begin
        logic [19:0] exp;
        recs[0]  = '{6'b100000, 6'b000000, 1'b1, 8, MEMADR, LBRD,   LBWR};
        recs[1]  = '{6'b101000, 6'b000000, 1'b0, 7, MEMADR, SBWR,   ZERO};
        recs[2]  = '{6'b000000, 6'b100010, 1'b1, 7, RT_SUB, RTWR,   ZERO};
        recs[3]  = '{6'b000000, 6'b101010, 1'b0, 7, RT_SLT, RTWR,   ZERO};
        recs[4]  = '{6'b000000, 6'b111111, 1'b1, 7, RT_ADD, RTWR,   ZERO};
        recs[5]  = '{6'b000000, 6'b100100, 1'b0, 7, RT_AND, RTWR,   ZERO};
        recs[6]  = '{6'b000000, 6'b100101, 1'b1, 7, RT_OR,  RTWR,   ZERO};
        recs[7]  = '{6'b000000, 6'b100000, 1'b0, 7, RT_ADD, RTWR,   ZERO};
        recs[8]  = '{6'b000100, 6'b000000, 1'b1, 6, BEQ_T,  ZERO,   ZERO};
        recs[9]  = '{6'b000100, 6'b000000, 1'b0, 6, BEQ_N,  ZERO,   ZERO};
        recs[10] = '{6'b000010, 6'b000000, 1'b1, 6, JEX,    ZERO,   ZERO};
        recs[11] = '{6'b001000, 6'b000000, 1'b0, 7, ADDIEX, ADDIWR, ZERO};

        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_hold%0d", i), outs, ZERO);
        end
        rst = 1'b0;
        step();

        // each record starts already in FETCH1
        for (int r = 0; r < 12; r++) begin
            op = recs[r].op;
            funct = recs[r].funct;
            zero = recs[r].zero;
            #1;
            chk($sformatf("rec%0d_c1", r), outs, F1);
            for (int c = 2; c <= recs[r].ncyc; c++) begin
                step();
                if (c <= 5)      exp = front(c);
                else if (c == 6) exp = recs[r].e0;
                else if (c == 7) exp = recs[r].e1;
                else             exp = recs[r].e2;
                chk($sformatf("rec%0d_c%0d", r, c), outs, exp);
            end
            step();
        end
        chk("final_fetch1", outs, F1);

        // zero toggling inside FETCH1 leaves pcen high
        zero = 1'b0;
        #1;
        chk("f1_zero0_pcen", {19'b0, pcen}, 20'd1);
        zero = 1'b1;
        #1;
        chk("f1_zero1_pcen", {19'b0, pcen}, 20'd1);

        // reset asserted in LBWR aborts the write at once
        op = 6'b100000;
        funct = 6'b0;
        for (int c = 2; c <= 8; c++) step();
        chk("lbwr_before_rst", outs, LBWR);
        rst = 1'b1;
        #1;
        chk("lbwr_rst_immediate", outs, ZERO);
        step();
        chk("lbwr_rst_held", outs, ZERO);
        rst = 1'b0;
        step();
        chk("lbwr_rst_restart", outs, F1);

        // illegal opcode
        op = 6'b111111;
        #1;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk($sformatf("illegal_c%0d", c), outs, front(c));
        end
        step();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal_halt_c6", outs, HALTV);
        op = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("halt_sticky%0d", i), outs, HALTV);
        end
        rst = 1'b1;
        #1;
        chk("halt_rst_clear", outs, ZERO);
        step();
        rst = 1'b0;
        step();
        chk("halt_rst_restart", outs, F1);
`else
        chk("illegal_nop_c6", outs, F1);
        op = 6'b000000;
        step();
        chk("illegal_nop_c7", outs, F2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // memread and memwrite must never coincide
    always @(negedge clk) begin
        if (memread && memwrite) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_wr_overlap got=11 exp=not both");
        end
    end

endmodule

// File: doc/tinymips_controller.md
# tinymips_controller

Multicycle control unit for the TinyMIPS 8-bit core. It sits directly upstream of the datapath and drives every datapath select, enable and ALU-control input. Its inputs are the opcode and funct fields of the instruction register and the ALU zero flag. A Moore state machine steps each instruction through a four-byte fetch, decode, execute, memory and writeback sequence. A small combinational decoder produces ALU control and the branch-qualified PC enable.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  datapath ALU-result-zero flag
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- alusrca  output  1  0 = PC, 1 = A register
- memtoreg  output  1  0 = aluout, 1 = MDR to register file
- iord  output  1  0 = PC, 1 = aluout as memory address
- pcen  output  1  PC register load enable
- regwrite  output  1  register file write enable
- regdst  output  1  0 = instr[18:16], 1 = instr[13:11] as write address
- pcsource  output  2  00 aluresult, 01 aluout, 10 constx4, 11 zero
- alusrcb  output  2  00 B, 01 constant 1, 10 instr[7:0], 11 constx4
- irwrite  output  4  one-hot byte load; bit3 loads instr[7:0], bit0 loads instr[31:24]
- alucont  output  3  ALU operation select
- halted  output  1  sticky illegal-opcode trap flag (see Configuration)

## Operation
- ALU codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000.
- Funct field for RTYPEEX: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct selects add.
- Every output not listed for a state is 0.

States and outputs:
- FETCH1..FETCH4: memread=1, iord=0, alusrca=0, alusrcb=01, alucont=add, pcsource=00, pcen=1. irwrite=1000, 0100, 0010, 0001 respectively. Each state advances to the next; FETCH4 goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, alucont=add (branch target into aluout). Next state by op:
  - LB or SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX
  - other → illegal handling (see Configuration)
- MEMADR: alusrca=1, alusrcb=10, alucont=add. Goes to LBRD if op=LB, else SBWR.
- LBRD: memread=1, iord=1 → LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0 → FETCH1.
- SBWR: memwrite=1, iord=1 → FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, alucont from funct → RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0 → FETCH1.
- BEQEX: alusrca=1, alusrcb=00, alucont=sub, pcsource=01, pcen=zero → FETCH1.
- JEX: pcsource=10, pcen=1 → FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, alucont=add → ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0 → FETCH1.
- pcen = pcwrite | (branch & zero). It is combinational from state and zero; it is the only zero-dependent output.

## Timing
- While rst=1, state is forced to FETCH1 and every output is forced to 0, including halted. The first FETCH1 outputs appear in the cycle after rst deasserts.
- Reset asserted mid-instruction aborts the instruction immediately. No partial regwrite or memwrite occurs after rst rises.
- Cycles per instruction, FETCH1 to the return to FETCH1: LB 8, SB 7, RTYPE 7, ADDI 7, BEQ 6, J 6.
- Outputs are valid combinationally within the state's cycle. The datapath captures on the next rising edge.
- Exactly one irwrite bit is high in fetch states; irwrite is 0000 in all other states.
- memread and memwrite are never both 1.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown op in DECODE moves to state HALT.
  - HALT drives halted=1 and all other outputs 0.
  - HALT is sticky until rst.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An unknown op in DECODE returns to FETCH1 as a 5-cycle NOP, with no register or memory write.
  - halted is tied 0.

## Test plan
- Reset: hold rst=1 for 3 cycles → all outputs 0. Release rst → next cycle memread=1, irwrite=1000, pcen=1, alusrcb=01.
- LB (op=100000) → sequence FETCH1-4, DECODE, MEMADR, LBRD, LBWR in 8 cycles. LBRD shows iord=1, memread=1. LBWR shows regwrite=1, memtoreg=1. Back in FETCH1 on cycle 9.
- RTYPE with funct=100010 → RTYPEEX alucont=110. funct=101010 → 111. funct=111111 → 010. RTYPEWR shows regdst=1, regwrite=1.
- BEQ: zero=1 in BEQEX → pcen=1, pcsource=01. Repeat with zero=0 → pcen=0. Toggling zero in FETCH1 leaves pcen=1 unchanged.
- op=111111: with CTRL_ILLEGAL_TRAP_EN, halted=1 from cycle 6 and stays 1 for 20 cycles until rst. Without the macro, FETCH1 is re-entered on cycle 6 and no regwrite or memwrite is seen.
- Assert rst during LBWR → regwrite drops to 0 immediately. After release, fetch restarts at FETCH1.
